// File: rtl/fir_coeff_loader.sv
// ---------------------------------------------------------------------------
// fir_coeff_loader
//
// Purpose
//   Upstream companion of the symmetric FIR lowpass filter. Takes exactly one
//   coefficient set from a valid/ready stream and replays it onto the FIR
//   coefficient-write port (we/data/addr). The FIR is held in
//   coefficient-write mode for the whole load, plus two flush cycles. This
//   keeps the FIR sample counters frozen until the last word has reached its
//   memory. Done/error status and a running checksum remain readable by
//   software until the next start.
//
// Ports
//   clk          in   1    system clock (FIR working-rate clock)
//   nrst         in   1    asynchronous active-low reset
//   start        in   1    one-cycle pulse, begins a load (only honoured in IDLE)
//   s_valid      in   1    coefficient beat valid
//   s_ready      out  1    loader can accept a beat (high in LOAD only)
//   s_data       in   C    coefficient, two's complement, index order 0..NC-1
//   s_last       in   1    marks the final beat of the set
//   fir_c_we     out  1    FIR coefficient write mode / write enable
//   fir_c_in     out  C    coefficient to FIR
//   fir_c_addr   out  AW   coefficient address to FIR
//   busy         out  1    high in LOAD and FLUSH
//   done         out  1    one-cycle pulse at the end of a load (ok or error)
//   err          out  1    sticky error flag, cleared by the next start
//   csum         out  C    sum mod 2^C of the coefficients accepted this load
//   o_dbg_state  out  2    current FSM state, for checkers and debug
//
// Handshake
//   A beat transfers on a rising clk edge where s_valid && s_ready are both
//   high. s_ready is a registered function of state and never depends on
//   s_valid. The source may present data and raise s_valid at any time. Once
//   it raises s_valid, it keeps s_data/s_last stable until the transfer.
//   s_data and s_last are ignored whenever s_valid is low.
// ---------------------------------------------------------------------------
module fir_coeff_loader #(
    parameter int ORD = 256,
    parameter int C   = 16,
    parameter int TMO = 1024,
    localparam int NC = (ORD + 1) >> 1,
    localparam int AW = $clog2(NC)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          start,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [C-1:0]  s_data,
    input  logic          s_last,
    output logic          fir_c_we,
    output logic [C-1:0]  fir_c_in,
    output logic [AW-1:0] fir_c_addr,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [C-1:0]  csum,
    output logic [1:0]    o_dbg_state
);

    // Idle timer only needs to reach TMO-1.
    localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;

    localparam logic [AW-1:0] LAST_IDX = AW'(NC - 1);
    localparam logic [TW-1:0] TMO_LIM  = TW'(TMO - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t        r_state;
    logic [AW-1:0] r_cnt;      // index of the next coefficient to accept
    logic [TW-1:0] r_timer;    // cycles since the last accepted beat
    logic          r_flush;    // second FLUSH cycle marker
    logic [C-1:0]  r_csum;
    logic          r_err;
    logic [C-1:0]  r_c_in;
    logic [AW-1:0] r_c_addr;
    logic          r_ready;
    logic          r_we;
    logic          r_busy;
    logic          r_done;

    // -----------------------------------------------------------------------
    // Next-state values
    // -----------------------------------------------------------------------
    state_t        w_state_nxt;
    logic [AW-1:0] w_cnt_nxt;
    logic [TW-1:0] w_timer_nxt;
    logic          w_flush_nxt;
    logic [C-1:0]  w_csum_nxt;
    logic          w_err_nxt;
    logic [C-1:0]  w_c_in_nxt;
    logic [AW-1:0] w_c_addr_nxt;
    logic          w_done_nxt;
    logic          w_accept;

    // r_ready is high only in LOAD, so this also qualifies the state.
    assign w_accept = s_valid && r_ready;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and datapath updates
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_timer_nxt  = r_timer;
        w_flush_nxt  = r_flush;
        w_csum_nxt   = r_csum;
        w_err_nxt    = r_err;
        w_c_in_nxt   = r_c_in;
        w_c_addr_nxt = r_c_addr;
        w_done_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                // The write port keeps its last word. Only the per-load
                // bookkeeping restarts.
                if (start) begin
                    w_state_nxt = S_LOAD;
                    w_cnt_nxt   = '0;
                    w_csum_nxt  = '0;
                    w_err_nxt   = 1'b0;
                    w_timer_nxt = '0;
                end
            end

            S_LOAD: begin
                if (w_accept) begin
                    w_c_in_nxt   = s_data;
                    w_c_addr_nxt = r_cnt;
                    w_csum_nxt   = r_csum + s_data;
                    w_cnt_nxt    = r_cnt + 1'b1;
                    w_timer_nxt  = '0;
                    // The set ends on s_last or when the coefficient memory is
                    // full. Only the two together are a correct set. On a
                    // long set, the beat at NC-1 is the last one taken.
                    if (s_last || (r_cnt == LAST_IDX)) begin
                        w_state_nxt = S_FLUSH;
                        w_flush_nxt = 1'b0;
                        if (!(s_last && (r_cnt == LAST_IDX))) begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end else if (r_timer == TMO_LIM) begin
                    // The source went silent. Abort, but still flush so the
                    // FIR sees a well-formed end of write mode.
                    w_state_nxt = S_FLUSH;
                    w_flush_nxt = 1'b0;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end

            S_FLUSH: begin
                // Two cycles cover the FIR's register on the write strobe
                // plus its memory write edge.
                if (r_flush) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_flush_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath and registered outputs
    // -----------------------------------------------------------------------
    // Every control output is decoded from the next state and then
    // registered, so these outputs change only at a clock edge. The FIR sees
    // no glitch on fir_c_we.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt    <= '0;
            r_timer  <= '0;
            r_flush  <= 1'b0;
            r_csum   <= '0;
            r_err    <= 1'b0;
            r_c_in   <= '0;
            r_c_addr <= '0;
            r_ready  <= 1'b0;
            r_we     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_timer  <= w_timer_nxt;
            r_flush  <= w_flush_nxt;
            r_csum   <= w_csum_nxt;
            r_err    <= w_err_nxt;
            r_c_in   <= w_c_in_nxt;
            r_c_addr <= w_c_addr_nxt;
            r_ready  <= (w_state_nxt == S_LOAD);
            r_we     <= (w_state_nxt != S_IDLE);
            r_busy   <= (w_state_nxt != S_IDLE);
            r_done   <= w_done_nxt;
        end
    end

    assign s_ready     = r_ready;
    assign fir_c_we    = r_we;
    assign fir_c_in    = r_c_in;
    assign fir_c_addr  = r_c_addr;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign csum        = r_csum;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fir_coeff_loader.sv
`timescale 1ns/1ps
module tb_fir_coeff_loader;

    localparam int ORD = 256;
    localparam int C   = 16;
    localparam int TMO = 16;
    localparam int NC  = (ORD + 1) >> 1;
    localparam int AW  = $clog2(NC);

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [C-1:0]  s_data = '0;
    logic          s_last = 1'b0;
    logic          fir_c_we;
    logic [C-1:0]  fir_c_in;
    logic [AW-1:0] fir_c_addr;
    logic          busy;
    logic          done;
    logic          err;
    logic [C-1:0]  csum;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    fir_coeff_loader #(.ORD(ORD), .C(C), .TMO(TMO)) dut (
        .clk(clk), .nrst(nrst), .start(start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .fir_c_we(fir_c_we), .fir_c_in(fir_c_in), .fir_c_addr(fir_c_addr),
        .busy(busy), .done(done), .err(err), .csum(csum),
        .o_dbg_state(dbg_state)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- bench state ----------------
    int n_tests = 0;
    int n_fail  = 0;

    logic [C-1:0]    beat_q[$];     // beats offered by the source, in order
    int              last_idx;      // beat index carrying s_last, -1 = none
    int              stall_mode;    // 0 none, 1 toggle, 2 random gaps
    int              start_mid_cyc; // cycle of a stray start pulse, -1 = none

    logic [AW+C-1:0] obs_q[$];      // {addr, data} seen one cycle after each accept
    logic [AW+C-1:0] exp_q[$];      // model: writes the FIR must see
    logic [C-1:0]    exp_csum;
    logic            exp_err;
    bit              exp_tmo;

    int              done_cnt, done_cyc, we_cyc, last_acc;
    logic            obs_err;
    logic [C-1:0]    obs_csum;
    bit              run_timeout;
    bit              busy_we_bad;

    // ---------------- reference model ----------------
    // A set is taken up to and including s_last, capped at NC beats. If the
    // source runs dry first, the load times out. Success needs exactly NC
    // beats with s_last on the last one.
    function automatic void build_expected();
        int m;
        exp_q.delete();
        exp_tmo = 1'b0;
        if (last_idx >= 0 && last_idx < NC && last_idx < beat_q.size()) m = last_idx + 1;
        else if (beat_q.size() >= NC) m = NC;
        else begin
            m = beat_q.size();
            exp_tmo = 1'b1;
        end
        exp_csum = '0;
        for (int k = 0; k < m; k++) begin
            exp_q.push_back({AW'(k), beat_q[k]});
            exp_csum = exp_csum + beat_q[k];
        end
        exp_err = !(m == NC && last_idx == NC - 1);
    endfunction

    task automatic fill_random(input int n);
        beat_q.delete();
        for (int k = 0; k < n; k++) beat_q.push_back(C'($urandom));
    endtask

    task automatic fill_ramp(input int n);
        beat_q.delete();
        for (int k = 0; k < n; k++) beat_q.push_back(C'(k));
    endtask

    // ---------------- driver / monitor ----------------
    // Issues start, then runs the source one cycle per falling edge. It
    // records what the write port shows one cycle after each accepted beat.
    task automatic run_load(input int max_cyc);
        int idx;
        bit acc_prev;
        bit finished;
        obs_q.delete();
        done_cnt = 0; done_cyc = -1; we_cyc = 0; last_acc = -1;
        obs_err = 1'b0; obs_csum = '0; busy_we_bad = 1'b0;
        idx = 0; acc_prev = 1'b0; finished = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            if (acc_prev) obs_q.push_back({fir_c_addr, fir_c_in});
            if (fir_c_we === 1'b1) we_cyc++;
            if (busy !== fir_c_we) busy_we_bad = 1'b1;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    obs_err  = err;
                    obs_csum = csum;
                end
            end
            if (done_cyc >= 0 && c >= done_cyc + 3) begin
                finished = 1'b1;
                break;
            end
            start = (c == start_mid_cyc);
            if (idx < beat_q.size() &&
                (stall_mode == 0 || (stall_mode == 1 && c % 2 == 0) ||
                 (stall_mode == 2 && $urandom_range(0, 3) != 0))) begin
                s_valid = 1'b1;
                s_data  = beat_q[idx];
                s_last  = (idx == last_idx);
            end else begin
                s_valid = 1'b0;
                s_data  = C'($urandom);
                s_last  = 1'($urandom_range(0, 1));
            end
            acc_prev = (s_valid === 1'b1) && (s_ready === 1'b1);
            if (acc_prev) begin
                last_acc = c;
                idx++;
            end
            @(negedge clk);
        end
        s_valid = 1'b0; s_last = 1'b0; start = 1'b0;
        run_timeout = !finished;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
        n_tests++; if (fir_c_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", fir_c_we); end
        n_tests++; if (fir_c_in !== '0) begin n_fail++; $display("FAIL reset_c_in: got %h want 0", fir_c_in); end
        n_tests++; if (fir_c_addr !== '0) begin n_fail++; $display("FAIL reset_c_addr: got %h want 0", fir_c_addr); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_tests++; if (csum !== '0) begin n_fail++; $display("FAIL reset_csum: got %h want 0", csum); end
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean_load();
        int bad;
        fill_ramp(NC); last_idx = NC - 1; stall_mode = 0; start_mid_cyc = -1;
        build_expected();
        run_load(600);
        n_tests++; if (run_timeout) begin n_fail++; $display("FAIL clean_bound: no done within 600 cycles"); end
        n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL clean_nwrites: got %0d want %0d", obs_q.size(), exp_q.size()); end
        bad = -1;
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) if (bad < 0 && obs_q[k] !== exp_q[k]) bad = k;
        n_tests++; if (bad >= 0) begin n_fail++; $display("FAIL clean_write[%0d]: got %h want %h", bad, obs_q[bad], exp_q[bad]); end
        n_tests++; if (obs_csum !== 16'h1FC0) begin n_fail++; $display("FAIL clean_csum: got %h want 1fc0", obs_csum); end
        n_tests++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL clean_err: got %b want 0", obs_err); end
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL clean_done_cnt: got %0d want 1", done_cnt); end
        n_tests++; if (done_cyc != last_acc + 3) begin n_fail++; $display("FAIL clean_done_cyc: got %0d want %0d", done_cyc, last_acc + 3); end
        n_tests++; if (we_cyc != NC + 2) begin n_fail++; $display("FAIL clean_we_len: got %0d want %0d", we_cyc, NC + 2); end
        n_tests++; if (busy_we_bad) begin n_fail++; $display("FAIL clean_busy: got busy!=we want busy==we"); end
    endtask

    // mode 1: valid toggles each cycle; mode 2: random gaps plus a stray start mid-load
    task automatic test_stalled(input int mode);
        int bad;
        fill_random(NC); last_idx = NC - 1; stall_mode = mode;
        start_mid_cyc = (mode == 2) ? 40 : -1;
        build_expected();
        run_load(1200);
        n_tests++; if (run_timeout) begin n_fail++; $display("FAIL stall%0d_bound: no done within 1200 cycles", mode); end
        n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stall%0d_nwrites: got %0d want %0d", mode, obs_q.size(), exp_q.size()); end
        bad = -1;
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) if (bad < 0 && obs_q[k] !== exp_q[k]) bad = k;
        n_tests++; if (bad >= 0) begin n_fail++; $display("FAIL stall%0d_write[%0d]: got %h want %h", mode, bad, obs_q[bad], exp_q[bad]); end
        n_tests++; if (obs_csum !== exp_csum) begin n_fail++; $display("FAIL stall%0d_csum: got %h want %h", mode, obs_csum, exp_csum); end
        n_tests++; if (obs_err !== exp_err) begin n_fail++; $display("FAIL stall%0d_err: got %b want %b", mode, obs_err, exp_err); end
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL stall%0d_done_cnt: got %0d want 1", mode, done_cnt); end
        n_tests++; if (we_cyc != done_cyc) begin n_fail++; $display("FAIL stall%0d_we_hold: got %0d high cycles want %0d", mode, we_cyc, done_cyc); end
        n_tests++; if (done_cyc != last_acc + 3) begin n_fail++; $display("FAIL stall%0d_done_cyc: got %0d want %0d", mode, done_cyc, last_acc + 3); end
    endtask

    // Short set (s_last early), long set (no s_last), and timeout (source dries up).
    task automatic test_bad_set(input string name, input int n_beats, input int lidx);
        int bad;
        int exp_done;
        fill_random(n_beats); last_idx = lidx; stall_mode = 0; start_mid_cyc = -1;
        build_expected();
        run_load(600);
        exp_done = last_acc + 3 + (exp_tmo ? TMO : 0);
        n_tests++; if (run_timeout) begin n_fail++; $display("FAIL %s_bound: no done within 600 cycles", name); end
        n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL %s_nwrites: got %0d want %0d", name, obs_q.size(), exp_q.size()); end
        bad = -1;
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) if (bad < 0 && obs_q[k] !== exp_q[k]) bad = k;
        n_tests++; if (bad >= 0) begin n_fail++; $display("FAIL %s_write[%0d]: got %h want %h", name, bad, obs_q[bad], exp_q[bad]); end
        n_tests++; if (obs_csum !== exp_csum) begin n_fail++; $display("FAIL %s_csum: got %h want %h", name, obs_csum, exp_csum); end
        n_tests++; if (obs_err !== exp_err) begin n_fail++; $display("FAIL %s_err: got %b want %b", name, obs_err, exp_err); end
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL %s_done_cnt: got %0d want 1", name, done_cnt); end
        n_tests++; if (done_cyc != exp_done) begin n_fail++; $display("FAIL %s_done_cyc: got %0d want %0d", name, done_cyc, exp_done); end
        n_tests++; if (we_cyc != done_cyc) begin n_fail++; $display("FAIL %s_we_hold: got %0d high cycles want %0d", name, we_cyc, done_cyc); end
    endtask

    // s_valid and start-free traffic in IDLE must not move anything; status holds.
    task automatic test_ignored_idle();
        bit moved;
        logic [1:0] st0;
        logic [AW+C-1:0] last_w;
        last_w = exp_q[exp_q.size() - 1];
        st0 = dbg_state;
        moved = 1'b0;
        for (int c = 0; c < 8; c++) begin
            s_valid = 1'b1; s_data = C'($urandom); s_last = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (s_ready !== 1'b0 || fir_c_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || dbg_state !== st0) moved = 1'b1;
        end
        s_valid = 1'b0; s_last = 1'b0;
        n_tests++; if (moved) begin n_fail++; $display("FAIL idle_quiet: got activity in IDLE want none"); end
        n_tests++; if ({fir_c_addr, fir_c_in} !== last_w) begin n_fail++; $display("FAIL idle_hold_write: got %h want %h", {fir_c_addr, fir_c_in}, last_w); end
        n_tests++; if (csum !== exp_csum) begin n_fail++; $display("FAIL idle_hold_csum: got %h want %h", csum, exp_csum); end
        n_tests++; if (err !== exp_err) begin n_fail++; $display("FAIL idle_hold_err: got %b want %b", err, exp_err); end
    endtask

    task automatic test_reset_mid_load();
        int n;
        int c;
        bit saw;
        fill_random(NC); last_idx = NC - 1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0; c = 0;
        while (n < 50 && c < 200) begin
            s_valid = 1'b1; s_data = beat_q[n]; s_last = 1'b0;
            if (s_ready === 1'b1) n++;
            @(negedge clk);
            c++;
        end
        n_tests++; if (n != 50) begin n_fail++; $display("FAIL rstmid_reach: got %0d beats want 50", n); end
        s_valid = 1'b1; s_data = beat_q[50];
        #2 nrst = 1'b0;
        #1;
        n_tests++; if ({s_ready, fir_c_we, fir_c_in, fir_c_addr, busy, done, err, csum} !== '0)
            begin n_fail++; $display("FAIL rstmid_async: got %h want 0", {s_ready, fir_c_we, fir_c_in, fir_c_addr, busy, done, err, csum}); end
        @(negedge clk);
        s_valid = 1'b0;
        n_tests++; if ({s_ready, fir_c_we, fir_c_in, fir_c_addr, busy, done, err, csum} !== '0)
            begin n_fail++; $display("FAIL rstmid_next: got %h want 0", {s_ready, fir_c_we, fir_c_in, fir_c_addr, busy, done, err, csum}); end
        nrst = 1'b1;
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw = 1'b1;
        end
        n_tests++; if (saw) begin n_fail++; $display("FAIL rstmid_no_done: got done/busy after reset want none"); end
        test_stalled(2);
    endtask

    initial begin
        test_reset();
        test_clean_load();
        test_stalled(1);
        test_stalled(2);
        test_bad_set("short", 20, 9);
        test_bad_set("long", NC + 12, -1);
        test_bad_set("timeout", 5, -1);
        test_ignored_idle();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
